// File: rtl/ram_sync_loader_if.sv
// Bus bundle for ram_sync_loader: address/data/strobes from the address register
// and program loader, registered read data and status back.
interface ram_sync_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  readEnable;
    logic                  writeEnable;
    logic                  loadEnable;
    logic                  loadRestart;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataValid;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] loadAddr;

    // Request strobes are single-cycle level commands sampled on each rising edge;
    // there is no ready: while busy is high every request is dropped, otherwise
    // each one is taken on the edge it is seen, and a read answers one edge later
    // with a one-cycle dataValid pulse.
    modport master (
        output addr, dataIn, readEnable, writeEnable, loadEnable, loadRestart,
        input  dataOut, dataValid, busy, loadAddr
    );

    modport slave (
        input  addr, dataIn, readEnable, writeEnable, loadEnable, loadRestart,
        output dataOut, dataValid, busy, loadAddr
    );
endinterface

// File: rtl/ram_sync_loader.sv
// Single-port synchronous RAM with registered read, post-reset hardware clear
// and an auto-incrementing sequential load port.
module ram_sync_loader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    ram_sync_loader_if.slave  bus,
    output logic              o_dbg_state
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] r_load_addr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dvalid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_idle = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Single write port shared by the clear sweep and the two user write paths;
    // reset itself must never disturb memory contents.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = bus.addr;
        w_wdata      = bus.dataIn;
        case (r_state)
            S_CLEAR: begin
                w_we    = !reset;
                w_waddr = r_clr_ptr;
                w_wdata = '0;
                if (r_clr_ptr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.writeEnable) begin
                    w_we = !reset;
                end else if (bus.loadEnable) begin
                    w_we    = !reset;
                    w_waddr = r_load_addr;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_ptr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read samples the pre-edge array, so a same-address write is read-first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout      <= '0;
            r_dvalid    <= 1'b0;
            r_load_addr <= '0;
        end else begin
            r_dvalid <= 1'b0;
            if (w_idle) begin
                if (bus.readEnable) begin
                    r_dout   <= r_mem[bus.addr];
                    r_dvalid <= 1'b1;
                end
                if (bus.loadRestart) begin
                    r_load_addr <= '0;
                end else if (bus.loadEnable && !bus.writeEnable) begin
                    r_load_addr <= r_load_addr + 1'b1;
                end
            end
        end
    end

    assign bus.dataOut   = r_dout;
    assign bus.dataValid = r_dvalid;
    assign bus.busy      = (r_state == S_CLEAR);
    assign bus.loadAddr  = r_load_addr;
    assign o_dbg_state   = r_state;
endmodule

// File: doc/ram_sync_loader.md
# ram_sync_loader

Parametrised single-port synchronous RAM, successor to the fixed 256x8 RAM in the 8-bit computer. It adds a registered read with a valid strobe, a hardware clear sequence after reset, and an auto-incrementing load port for filling program memory sequentially. It sits between the bus/memory-address register and the program loader, and replaces the old RAM.

## Interface
- DATA_WIDTH, 8, word width in bits (>=1)
- ADDR_WIDTH, 8, address width; depth DEPTH = 2**ADDR_WIDTH words
- CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = skip the clear (contents undefined after power-up)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  read/write address
- dataIn  in  DATA_WIDTH  write data for both writeEnable and loadEnable
- readEnable  in  1  request a read of addr
- writeEnable  in  1  write dataIn to addr
- loadEnable  in  1  write dataIn to loadAddr, then increment loadAddr
- loadRestart  in  1  set loadAddr to 0
- dataOut  out  DATA_WIDTH  registered read data
- dataValid  out  1  one-cycle pulse: dataOut was updated on this edge
- busy  out  1  clear sequence in progress; user requests ignored
- loadAddr  out  ADDR_WIDTH  next load-port address

## Operation
- Reset values: dataOut = 0, dataValid = 0, loadAddr = 0, busy = CLEAR_ON_RESET, internal clear pointer = 0.
- Reset is taken in any state and restarts the clear sequence from address 0.
- Memory contents are not changed by reset itself; only the clear sequence changes them.
- State machine has two states, CLEAR and IDLE.
  - Reset selects CLEAR when CLEAR_ON_RESET = 1, otherwise IDLE.
  - CLEAR writes 0 to the clear pointer's address each cycle and increments the pointer. After it writes DEPTH-1 it moves to IDLE and busy falls.
  - In CLEAR, readEnable, writeEnable, loadEnable and loadRestart are ignored. dataValid stays 0 and loadAddr is not changed.
- IDLE priority among writes:
  1. writeEnable writes mem[addr] = dataIn.
  2. Otherwise loadEnable writes mem[loadAddr] = dataIn and sets loadAddr = loadAddr + 1, wrapping from DEPTH-1 to 0.
  - If both are asserted, only the writeEnable write happens and loadAddr holds.
- loadRestart:
  - Sets loadAddr to 0 and has priority over the increment.
  - loadRestart together with loadEnable: the load write goes to the old loadAddr, and loadAddr then becomes 0.
- Read: readEnable in IDLE loads dataOut with mem[addr] on the next edge and sets dataValid = 1 for that cycle. Otherwise dataValid = 0 and dataOut holds its last value.
- Read and write to the same address in the same cycle is read-first: dataOut gets the old contents and the new value is stored. This applies to both writeEnable and loadEnable.
- Addresses are always in range, since DEPTH = 2**ADDR_WIDTH. There is no out-of-range case.

## Timing
- Read latency is 1 cycle: readEnable sampled at edge N gives dataOut and dataValid valid after edge N.
- Back-to-back reads give one result per cycle, with dataValid held high.
- Write latency is 1 cycle: a write at edge N is visible to a read sampled at edge N+1.
- Clear duration: busy is 1 during reset and for exactly DEPTH cycles after reset is released. It is 0 after the edge that writes address DEPTH-1.
  - Example: DEPTH = 256 gives 256 cycles.
- With CLEAR_ON_RESET = 0, busy = 0 on the first cycle after reset is released.
- Outputs are purely registered: no combinational path from inputs to outputs.

## Test plan
- Clear: DW=8, AW=8. Pulse reset for 2 cycles, then count cycles with busy=1 -> count is exactly 256. Then read addresses 0..255 -> all 0x00, each with a 1-cycle dataValid.
- Write/read sweep: write mem[i] = i for i = 0..255, then issue 256 back-to-back reads -> dataOut = i one cycle after each request, and dataValid stays high for all 256 cycles.
- Load port: loadRestart, then 258 loadEnable writes with dataIn = 0xA0 + n (mod 256) -> loadAddr wraps 255 -> 0 -> 2. Addresses 0 and 1 hold the last two values (0xA0 and 0xA1), and address 2 holds 0xA2.
- Collisions:
  - mem[5] = 0x11. Same-cycle readEnable + writeEnable with addr = 5, dataIn = 0x22 -> dataOut = 0x11. A following read returns 0x22.
  - writeEnable and loadEnable together -> only mem[addr] changes, and loadAddr is unchanged.
- Reset mid-operation:
  - Assert reset at clear cycle 100 -> busy stays 1, and the clear restarts with a full 256 cycles.
  - Assert reset with loadAddr = 7 -> loadAddr = 0, dataOut = 0, dataValid = 0.
- Ignored requests: readEnable and writeEnable (addr 3, 0xFF) while busy -> no dataValid. After the clear, mem[3] = 0x00.
- Parameter variant: DW=16, AW=4. The clear takes 16 cycles, and a write/read of 0xBEEF at address 15 returns 0xBEEF.
